// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and elaboration-time helpers for the
// parametrised synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(
    input int depth,
    input int ae,
    input int af
  );
    return is_pow2(depth) && (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param.
// master = user side, slave = FIFO side.
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  localparam int CW = clog2(DEPTH) + 1;

  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wr_en, data_in, rd_en,
    input  data_out, full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, data_in, rd_en,
    output data_out, full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_param_mem.sv
// Simple dual-port register array with a registered,
// reset-to-zero read port that holds when not read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy,
// registered status flags and error pulses around fifo_mem.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic clk,
  input  logic rst_n,
  fifo_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  if (!params_ok(DEPTH, AE_THRESH, AF_THRESH)) begin : g_bad_params
    $error("sync_fifo_param: illegal DEPTH/threshold parameters");
  end

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc, rd_acc;
  logic          mem_we, mem_re;

  // A full FIFO still takes a write when a read frees a slot
  assign rd_acc = bus.rd_en && !empty_q;
  assign wr_acc = bus.wr_en && (!full_q || rd_acc);
  assign mem_we = wr_acc && !bus.clr;
  assign mem_re = rd_acc && !bus.clr;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (bus.clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      unique case (1'b1)
        (wr_acc && !rd_acc): count_d = count_q + 1'b1;
        (rd_acc && !wr_acc): count_d = count_q - 1'b1;
        default:             count_d = count_q;
      endcase
      ovf_d = bus.wr_en && !wr_acc;
      unf_d = bus.rd_en && !rd_acc;
    end
    full_d  = (count_d == PW'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= PW'(AF_THRESH));
    ae_d    = (count_d <= PW'(AE_THRESH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (wptr_q[AW-1:0]),
    .wdata (bus.data_in),
    .re    (mem_re),
    .raddr (rptr_q[AW-1:0]),
    .rdata (bus.data_out)
  );

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: queue model checked
// every cycle plus hand-computed literal expectations.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int D  = 16;
  localparam int AF = D - 2;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_if #(.DATA_W(DW), .DEPTH(D)) bus ();

  sync_fifo_param #(
    .DATA_W    (DW),
    .DEPTH     (D),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_dout = '0;
  bit            m_ovf  = 1'b0;
  bit            m_unf  = 1'b0;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h",
               name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit rd_ok, wr_ok;
    rd_ok = bus.rd_en && (mq.size() > 0);
    wr_ok = bus.wr_en && ((mq.size() < D) || rd_ok);
    if (bus.clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (rd_ok) m_dout = mq.pop_front();
      if (wr_ok) mq.push_back(bus.data_in);
      m_ovf = bus.wr_en && !wr_ok;
      m_unf = bus.rd_en && !rd_ok;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("count", 32'(bus.count), 32'(mq.size()));
      check("full", 32'(bus.full), 32'(mq.size() == D));
      check("empty", 32'(bus.empty), 32'(mq.size() == 0));
      check("almost_full", 32'(bus.almost_full),
            32'(mq.size() >= AF));
      check("almost_empty", 32'(bus.almost_empty),
            32'(mq.size() <= AE));
      check("data_out", 32'(bus.data_out), 32'(m_dout));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("underflow", 32'(bus.underflow), 32'(m_unf));
    end
  end

  task automatic step(
    input bit          w,
    input logic [DW-1:0] d,
    input bit          r,
    input bit          c
  );
    bus.wr_en   = w;
    bus.data_in = d;
    bus.rd_en   = r;
    bus.clr     = c;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clr   = 1'b0;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr     = 1'b0;
    bus.data_in = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_ae", 32'(bus.almost_empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_dout", 32'(bus.data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // underflow after reset
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_pulse", 32'(bus.underflow), 32'd1);
    check("unf_dout", 32'(bus.data_out), 32'h00);
    check("unf_count", 32'(bus.count), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("unf_clear", 32'(bus.underflow), 32'd0);

    // ordered data
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    check("ord_count3", 32'(bus.count), 32'd3);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("ord_a1", 32'(bus.data_out), 32'hA1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("ord_b2", 32'(bus.data_out), 32'hB2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("ord_c3", 32'(bus.data_out), 32'hC3);
    check("ord_empty", 32'(bus.empty), 32'd1);

    // fill and overflow
    for (int i = 0; i < D; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 12) check("af_13", 32'(bus.almost_full), 32'd0);
      if (i == 13) check("af_14", 32'(bus.almost_full), 32'd1);
      if (i == 14) check("full_15", 32'(bus.full), 32'd0);
    end
    check("full_16", 32'(bus.full), 32'd1);
    check("count_16", 32'(bus.count), 32'd16);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_pulse", 32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd16);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf_clear", 32'(bus.overflow), 32'd0);

    // read+write while full
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("rw_full_cnt", 32'(bus.count), 32'd16);
    check("rw_full_flag", 32'(bus.full), 32'd1);
    check("rw_full_ovf", 32'(bus.overflow), 32'd0);
    check("rw_full_dout", 32'(bus.data_out), 32'h00);
    for (int i = 1; i < D; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain", 32'(bus.data_out), 32'(i));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_55", 32'(bus.data_out), 32'h55);
    check("drain_empty", 32'(bus.empty), 32'd1);

    // read+write while empty
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("rw_empty_cnt", 32'(bus.count), 32'd1);
    check("rw_empty_unf", 32'(bus.underflow), 32'd1);
    check("rw_empty_dout", 32'(bus.data_out), 32'h55);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("rw_empty_77", 32'(bus.data_out), 32'h77);

    // pointer wrap at steady occupancy 5
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(i + 5), 1'b1, 1'b0);
      check("wrap_dout", 32'(bus.data_out), 32'(i));
    end
    check("wrap_count", 32'(bus.count), 32'd5);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_last", 32'(bus.data_out), 32'd44);

    // mid-cycle asynchronous reset
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_count", 32'(bus.count), 32'd0);
    check("mrst_empty", 32'(bus.empty), 32'd1);
    check("mrst_ae", 32'(bus.almost_empty), 32'd1);
    check("mrst_dout", 32'(bus.data_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'hD4, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("mrst_d4", 32'(bus.data_out), 32'hD4);
    check("mrst_empty2", 32'(bus.empty), 32'd1);

    // synchronous flush
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("clr_pre", 32'(bus.data_out), 32'h80);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    check("clr_count", 32'(bus.count), 32'd0);
    check("clr_empty", 32'(bus.empty), 32'd1);
    check("clr_dout", 32'(bus.data_out), 32'h80);
    check("clr_ovf", 32'(bus.overflow), 32'd0);
    check("clr_unf", 32'(bus.underflow), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("clr_unf2", 32'(bus.underflow), 32'd1);
    step(1'b1, 8'hD4, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("clr_d4", 32'(bus.data_out), 32'hD4);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
